// File: rtl/bit_unpermute_stream.sv
// bit_unpermute_stream: loads a forward bit map, checks it is a bijection, then restores permuted words on a stream
module bit_unpermute_stream #(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [IDX_W-1:0] cfg_src,
   input  logic             cfg_done,
   output logic             cfg_busy,
   output logic             cfg_ok,
   output logic             cfg_err,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);
   typedef enum logic [2:0] {UNCFG, LOAD, CHECK, ACTIVE, ERROR} state_t;
   localparam logic [IDX_W:0]   WIDTH_X = (IDX_W+1)'(WIDTH);
   localparam logic [IDX_W-1:0] LAST_K  = IDX_W'(WIDTH-1);
   state_t           state_q, state_d;
   logic [IDX_W-1:0] fwd_q [WIDTH];
   logic [IDX_W-1:0] fwd_d [WIDTH];
   logic [IDX_W-1:0] inv_q [WIDTH];
   logic [IDX_W-1:0] inv_d [WIDTH];
   logic [WIDTH-1:0] used_q, used_d;
   logic             err_q, err_d;
   logic [IDX_W-1:0] k_q, k_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [WIDTH-1:0] restored;
   logic [IDX_W-1:0] cur;
   logic             start_ok, cur_bad, accept;
   assign cfg_busy  = (state_q == LOAD) || (state_q == CHECK);
   assign cfg_ok    = state_q == ACTIVE;
   assign cfg_err   = state_q == ERROR;
   assign in_ready  = (state_q == ACTIVE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   // configuration FSM: map load, one-entry-per-cycle bijection scan, inverse table build
   always_comb begin
      state_d  = state_q;
      fwd_d    = fwd_q;
      inv_d    = inv_q;
      used_d   = used_q;
      err_d    = err_q;
      k_d      = k_q;
      start_ok = cfg_start && ((state_q == UNCFG) || (state_q == ERROR) || ((state_q == ACTIVE) && !out_valid_q));
      cur      = fwd_q[k_q];
      cur_bad  = ({1'b0, cur} >= WIDTH_X) || used_q[cur];
      if (start_ok) begin
         state_d = LOAD;
         for (int i = 0; i < WIDTH; i++) fwd_d[i] = IDX_W'(i);
      end else begin
         case (state_q)
            LOAD: begin
               if (cfg_valid && ({1'b0, cfg_idx} < WIDTH_X)) fwd_d[cfg_idx] = cfg_src;
               if (cfg_done) begin
                  state_d = CHECK;
                  used_d  = '0;
                  err_d   = 1'b0;
                  k_d     = '0;
               end
            end
            CHECK: begin
               if (cur_bad) err_d = 1'b1;
               else begin
                  used_d[cur] = 1'b1;
                  inv_d[cur]  = k_q;
               end
               if (k_q == LAST_K) state_d = err_d ? ERROR : ACTIVE;
               else k_d = k_q + 1'b1;
            end
            default: ;
         endcase
      end
   end
   // datapath: gather each original bit from its permuted position, hold under backpressure
   always_comb begin
      for (int j = 0; j < WIDTH; j++) restored[j] = in_data[inv_q[j]];
      out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
      out_data_d  = accept ? restored : out_data_q;
   end
   // state registers with asynchronous reset to the unconfigured identity map
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= UNCFG;
         for (int i = 0; i < WIDTH; i++) begin
            fwd_q[i] <= IDX_W'(i);
            inv_q[i] <= IDX_W'(i);
         end
         used_q      <= '0;
         err_q       <= 1'b0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         fwd_q       <= fwd_d;
         inv_q       <= inv_d;
         used_q      <= used_d;
         err_q       <= err_d;
         k_q         <= k_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end
endmodule

// File: tb/tb_bit_unpermute_stream.sv
// tb_bit_unpermute_stream: directed checks of map load, bijection check, streaming restore and backpressure
module tb_bit_unpermute_stream;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_start = 1'b0, cfg_valid = 1'b0, cfg_done = 1'b0;
   logic [2:0] cfg_idx = '0, cfg_src = '0;
   logic       cfg_busy, cfg_ok, cfg_err;
   logic       in_valid = 1'b0, in_ready;
   logic [7:0] in_data = '0;
   logic       out_valid, out_ready = 1'b0;
   logic [7:0] out_data;
   int         total = 0, bad = 0;

   bit_unpermute_stream #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_src(cfg_src), .cfg_done(cfg_done),
      .cfg_busy(cfg_busy), .cfg_ok(cfg_ok), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] mk(input int f7, f6, f5, f4, f3, f2, f1, f0);
      return {f7[2:0], f6[2:0], f5[2:0], f4[2:0], f3[2:0], f2[2:0], f1[2:0], f0[2:0]};
   endfunction

   // writes the first n entries of m (fwd[i] = m[3i+:3]), done coincides with the last write
   task automatic load_map(input string tag, input logic [23:0] m, input int n, input bit exp_ok);
      cfg_start = 1'b1;
      tick;
      cfg_start = 1'b0;
      chk({tag, "_load_busy"}, cfg_busy, 1);
      chk({tag, "_load_clr"}, {cfg_ok, cfg_err}, 0);
      if (n == 0) begin
         cfg_done = 1'b1;
         tick;
      end else begin
         for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            cfg_idx   = i[2:0];
            cfg_src   = m[3*i +: 3];
            cfg_done  = (i == n - 1);
            tick;
         end
      end
      cfg_valid = 1'b0;
      cfg_done  = 1'b0;
      repeat (7) tick;
      chk({tag, "_early"}, {cfg_busy, cfg_ok, cfg_err}, 3'b100);
      tick;
      chk({tag, "_result"}, {cfg_busy, cfg_ok, cfg_err}, {1'b0, exp_ok, !exp_ok});
   endtask

   task automatic send(input string tag, input logic [7:0] din, input logic [7:0] exp);
      in_valid = 1'b1;
      in_data  = din;
      tick;
      chk(tag, {out_valid, out_data}, {1'b1, exp});
   endtask

   task automatic drain(input string tag);
      in_valid = 1'b0;
      tick;
      chk(tag, out_valid, 0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) tick;
      chk("reset_outs", {cfg_busy, cfg_ok, cfg_err, in_ready, out_valid, out_data}, 0);
      rst_n = 1'b1;
      tick;
      out_ready = 1'b1;
      // identity with no writes, exact 9-cycle ok latency
      load_map("ident", mk(7, 6, 5, 4, 3, 2, 1, 0), 0, 1'b1);
      chk("ident_ready", in_ready, 1);
      send("ident_3c", 8'h3C, 8'h3C);
      drain("ident_drain");
      // mixed map, back-to-back words
      load_map("mix", mk(7, 6, 4, 5, 0, 3, 2, 1), 8, 1'b1);
      send("mix_9a", 8'h9A, 8'hA5);
      send("mix_ff", 8'hFF, 8'hFF);
      send("mix_00", 8'h00, 8'h00);
      drain("mix_drain");
      // reversal
      load_map("rev", mk(0, 1, 2, 3, 4, 5, 6, 7), 8, 1'b1);
      send("rev_01", 8'h01, 8'h80);
      send("rev_80", 8'h80, 8'h01);
      send("rev_0f", 8'h0F, 8'hF0);
      drain("rev_drain");
      // duplicate source index -> error, nothing accepted
      load_map("dup", mk(7, 6, 5, 4, 3, 2, 3, 3), 2, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h55;
      for (int i = 0; i < 3; i++) begin
         chk("dup_ready", in_ready, 0);
         tick;
         chk("dup_outv", out_valid, 0);
      end
      chk("dup_err_hold", {cfg_ok, cfg_err}, 2'b01);
      in_valid = 1'b0;
      load_map("recover", mk(7, 6, 5, 4, 3, 2, 1, 0), 0, 1'b1);
      // backpressure with ignored cfg_start
      load_map("bp", mk(0, 1, 2, 3, 4, 5, 6, 7), 8, 1'b1);
      out_ready = 1'b0;
      send("bp_first", 8'h01, 8'h80);
      in_data = 8'h0F;
      for (int i = 0; i < 5; i++) begin
         cfg_start = (i == 2);
         chk("bp_ready", in_ready, 0);
         tick;
         chk("bp_hold", {out_valid, out_data}, {1'b1, 8'h80});
         chk("bp_cfg", {cfg_busy, cfg_ok}, 2'b01);
      end
      cfg_start = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      tick;
      chk("bp_next", {out_valid, out_data}, {1'b1, 8'hF0});
      drain("bp_drain");
      // reset mid-check
      cfg_start = 1'b1;
      tick;
      cfg_start = 1'b0;
      cfg_done = 1'b1;
      tick;
      cfg_done = 1'b0;
      repeat (3) tick;
      chk("mid_busy", cfg_busy, 1);
      in_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("mid_reset", {cfg_busy, cfg_ok, cfg_err, in_ready, out_valid, out_data}, 0);
      tick;
      rst_n = 1'b1;
      tick;
      chk("post_reset", {cfg_busy, cfg_ok, cfg_err, in_ready, out_valid}, 0);
      in_valid = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
